// File: rtl/seg_scan_receiver_if.sv
// Signal bundle between a multiplexed 7-segment display driver and the
// scan receiver: the raw driver pins plus the decoded frame results.
interface seg_scan_receiver_if;
  logic [3:0] scan;
  logic [6:0] display;
  logic [3:0] dig3;
  logic [3:0] dig2;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic [3:0] blank;
  logic       frame_valid;
  logic       seg_err;
  logic       scan_err;
  logic       seq_err;
  logic [7:0] err_count;
  logic       link_lost;

  // Display-driver side: drives the pins, observes the decoded results.
  modport master (
    output scan, display,
    input  dig3, dig2, dig1, dig0, blank, frame_valid,
    input  seg_err, scan_err, seq_err, err_count, link_lost
  );

  // Receiver side: samples the pins, produces the decoded results.
  modport slave (
    input  scan, display,
    output dig3, dig2, dig1, dig0, blank, frame_valid,
    output seg_err, scan_err, seq_err, err_count, link_lost
  );
endinterface

// File: rtl/seg_scan_receiver.sv
// Receiver for a multiplexed 4-digit 7-segment display bus. Synchronizes the
// asynchronous scan/segment pins, captures a digit once its pin state has been
// stable long enough, decodes it, and assembles digits 3..0 into a frame.
//
// Sequence FSM states:
//   state | meaning
//   WAIT3 | idle / resync; waiting for a digit3 capture to start a frame
//   GOT3  | digit3 stored in shadow, expecting digit2
//   GOT2  | digits 3..2 stored, expecting digit1
//   GOT1  | digits 3..1 stored, expecting digit0 to complete the frame
module seg_scan_receiver #(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT       = 262144
) (
  input  logic               clk,
  input  logic               reset,
  seg_scan_receiver_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0]    STAB_CAP = 8'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {WAIT3, GOT3, GOT2, GOT1} state_t;

  // Result packed as {valid, blank, value}; blank decodes to value 0.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: return {2'b10, 4'd0};
      7'b0110000: return {2'b10, 4'd1};
      7'b1101101: return {2'b10, 4'd2};
      7'b1111001: return {2'b10, 4'd3};
      7'b0110011: return {2'b10, 4'd4};
      7'b1011011: return {2'b10, 4'd5};
      7'b1011111: return {2'b10, 4'd6};
      7'b1110000: return {2'b10, 4'd7};
      7'b1111111: return {2'b10, 4'd8};
      7'b1111011: return {2'b10, 4'd9};
      7'b0000000: return {2'b11, 4'd0};
      default:    return 6'b00_0000;
    endcase
  endfunction

  logic [3:0]    scan_s1, scan_s2;
  logic [6:0]    disp_s1, disp_s2;
  logic [10:0]   prev_q;
  logic [10:0]   sample;
  logic [7:0]    stab_cnt;
  logic          capture;
  logic [3:0]    cap_scan;
  logic [6:0]    cap_seg;
  logic          scan_onehot;
  logic [1:0]    cap_digit;
  logic [5:0]    dec;
  logic          dec_ok;
  logic          dec_blank;
  logic [3:0]    dec_val;
  logic          cap_ok;
  logic          scan_bad;
  logic          seg_bad;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  state_t        state_q, state_d;
  logic          seq_err_d;
  logic          frame_done;
  logic [3:0]    slot_we;
  logic [3:0]    sh_val [4];
  logic [3:0]    sh_blank;

  assign sample = {scan_s2, disp_s2};

  // Two-flop synchronizer on the pins, plus the run-length stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_s1  <= '0;
      scan_s2  <= '0;
      disp_s1  <= '0;
      disp_s2  <= '0;
      prev_q   <= '0;
      stab_cnt <= '0;
    end else begin
      scan_s1 <= bus.scan;
      scan_s2 <= scan_s1;
      disp_s1 <= bus.display;
      disp_s2 <= disp_s1;
      prev_q  <= sample;
      if (sample != prev_q)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // The counter passes STAB_CAP exactly once per stable run, so this fires once.
  assign capture  = (stab_cnt == STAB_CAP);
  assign cap_scan = prev_q[10:7];
  assign cap_seg  = prev_q[6:0];

  // Classify the captured digit select; anything but a single bit is a scan error.
  always_comb begin
    scan_onehot = 1'b1;
    cap_digit   = 2'd0;
    case (cap_scan)
      4'b1000: cap_digit = 2'd3;
      4'b0100: cap_digit = 2'd2;
      4'b0010: cap_digit = 2'd1;
      4'b0001: cap_digit = 2'd0;
      default: scan_onehot = 1'b0;
    endcase
  end

  assign dec       = seg_decode(cap_seg);
  assign dec_ok    = dec[5];
  assign dec_blank = dec[4];
  assign dec_val   = dec[3:0];

  // Scan errors take precedence: a bad select means the segments are not examined.
  assign scan_bad = capture && !scan_onehot;
  assign seg_bad  = capture && scan_onehot && !dec_ok;
  assign cap_ok   = capture && scan_onehot && dec_ok;

  // A valid capture in the same cycle suppresses the timeout.
  assign tmo_hit = !cap_ok && (tmo_cnt == TMO_LAST);

  // Link-activity timer: restarts on every valid capture, parks at TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset)
      tmo_cnt <= '0;
    else if (cap_ok)
      tmo_cnt <= '0;
    else if (tmo_cnt != TMO_MAX)
      tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Sequence FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= WAIT3;
    else
      state_q <= state_d;
  end

  // Sequence FSM next state, shadow-slot loads and sequence errors.
  always_comb begin
    state_d    = state_q;
    seq_err_d  = 1'b0;
    frame_done = 1'b0;
    slot_we    = 4'b0000;
    if (cap_ok) begin
      case (cap_digit)
        2'd3: begin
          slot_we[3] = 1'b1;
          state_d    = GOT3;
        end
        2'd2: begin
          if (state_q == GOT3) begin
            slot_we[2] = 1'b1;
            state_d    = GOT2;
          end else if (state_q != WAIT3) begin
            seq_err_d = 1'b1;
            state_d   = WAIT3;
          end
        end
        2'd1: begin
          if (state_q == GOT2) begin
            slot_we[1] = 1'b1;
            state_d    = GOT1;
          end else if (state_q != WAIT3) begin
            seq_err_d = 1'b1;
            state_d   = WAIT3;
          end
        end
        default: begin
          if (state_q == GOT1) begin
            slot_we[0] = 1'b1;
            frame_done = 1'b1;
            state_d    = WAIT3;
          end else if (state_q != WAIT3) begin
            seq_err_d = 1'b1;
            state_d   = WAIT3;
          end
        end
      endcase
    end else if (seg_bad || tmo_hit) begin
      state_d = WAIT3;
    end
  end

  // Shadow slots collect the frame; digit0 goes straight to the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) sh_val[i] <= '0;
      sh_blank <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (slot_we[i]) begin
          sh_val[i]   <= dec_val;
          sh_blank[i] <= dec_blank;
        end
      end
    end
  end

  // Frame outputs update together on completion; link_lost clears with frame_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dig3        <= '0;
      bus.dig2        <= '0;
      bus.dig1        <= '0;
      bus.dig0        <= '0;
      bus.blank       <= 4'b1111;
      bus.frame_valid <= 1'b0;
      bus.link_lost   <= 1'b1;
    end else begin
      bus.frame_valid <= frame_done;
      if (frame_done) begin
        bus.dig3      <= sh_val[3];
        bus.dig2      <= sh_val[2];
        bus.dig1      <= sh_val[1];
        bus.dig0      <= dec_val;
        bus.blank     <= {sh_blank[3], sh_blank[2], sh_blank[1], dec_blank};
        bus.link_lost <= 1'b0;
      end else if (tmo_hit) begin
        bus.link_lost <= 1'b1;
      end
    end
  end

  // Error pulses and their saturating tally.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.seg_err   <= 1'b0;
      bus.scan_err  <= 1'b0;
      bus.seq_err   <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.seg_err  <= seg_bad;
      bus.scan_err <= scan_bad;
      bus.seq_err  <= seq_err_d;
      if ((bus.seg_err || bus.scan_err || bus.seq_err) && bus.err_count != 8'hFF)
        bus.err_count <= bus.err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_seg_scan_receiver.sv
// Directed bench for seg_scan_receiver: frames, blanks, error paths,
// glitch rejection, link timeout and mid-frame reset.
module tb_seg_scan_receiver;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SB = 7'b0000000;
  localparam logic [6:0] SX = 7'b1000000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   fv_cnt = 0;
  int   seg_cnt = 0;
  int   scan_cnt = 0;
  int   seq_cnt = 0;
  logic ll_at_fv = 1'b1;

  seg_scan_receiver_if bus ();

  seg_scan_receiver #(.STABLE_CYCLES(16), .TIMEOUT(1000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.frame_valid) begin
      fv_cnt   = fv_cnt + 1;
      ll_at_fv = bus.link_lost;
    end
    if (bus.seg_err)  seg_cnt  = seg_cnt + 1;
    if (bus.scan_err) scan_cnt = scan_cnt + 1;
    if (bus.seq_err)  seq_cnt  = seq_cnt + 1;
  end

  task automatic hold(input logic [3:0] s, input logic [6:0] d, input int n);
    bus.scan    = s;
    bus.display = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [6:0] d3, input logic [6:0] d2,
                            input logic [6:0] d1, input logic [6:0] d0);
    hold(4'b1000, d3, 40);
    hold(4'b0100, d2, 40);
    hold(4'b0010, d1, 40);
    hold(4'b0001, d0, 40);
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    bus.scan    = 4'b1000;
    bus.display = S1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.dig3, bus.dig2, bus.dig1, bus.dig0} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_digits got=%h exp=0000", {bus.dig3, bus.dig2, bus.dig1, bus.dig0});
    end
    checks++;
    if (bus.blank !== 4'b1111) begin
      failures++;
      $display("FAIL reset_blank got=%b exp=1111", bus.blank);
    end
    checks++;
    if ({bus.frame_valid, bus.seg_err, bus.scan_err, bus.seq_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pulses got=%b exp=0000",
               {bus.frame_valid, bus.seg_err, bus.scan_err, bus.seq_err});
    end
    checks++;
    if (bus.err_count !== 8'd0 || bus.link_lost !== 1'b1) begin
      failures++;
      $display("FAIL reset_cnt_link got=%0d/%b exp=0/1", bus.err_count, bus.link_lost);
    end
    reset = 1'b0;
  endtask

  task automatic test_frame;
    int fv0 = fv_cnt;
    send_frame(S1, S2, S3, S4);
    checks++;
    if (fv_cnt - fv0 !== 1) begin
      failures++;
      $display("FAIL frame_valid_count got=%0d exp=1", fv_cnt - fv0);
    end
    checks++;
    if ({bus.dig3, bus.dig2, bus.dig1, bus.dig0} !== 16'h1234 || bus.blank !== 4'b0000) begin
      failures++;
      $display("FAIL frame_digits got=%h/%b exp=1234/0000",
               {bus.dig3, bus.dig2, bus.dig1, bus.dig0}, bus.blank);
    end
    checks++;
    if (bus.link_lost !== 1'b0 || ll_at_fv !== 1'b0) begin
      failures++;
      $display("FAIL frame_link got=%b at_fv=%b exp=0", bus.link_lost, ll_at_fv);
    end
  endtask

  task automatic test_blank;
    int fv0 = fv_cnt;
    send_frame(S1, SB, S3, S4);
    checks++;
    if (fv_cnt - fv0 !== 1 || {bus.dig3, bus.dig2, bus.dig1, bus.dig0} !== 16'h1034
        || bus.blank !== 4'b0100) begin
      failures++;
      $display("FAIL blank_frame got=%0d %h/%b exp=1 1034/0100", fv_cnt - fv0,
               {bus.dig3, bus.dig2, bus.dig1, bus.dig0}, bus.blank);
    end
  endtask

  task automatic test_seg_err;
    int fv0 = fv_cnt;
    int se0 = seg_cnt;
    hold(4'b1000, S1, 40);
    hold(4'b0100, S2, 40);
    hold(4'b0010, SX, 40);
    hold(4'b0001, S4, 40);
    checks++;
    if (seg_cnt - se0 !== 1 || bus.err_count !== 8'd1) begin
      failures++;
      $display("FAIL seg_err got=%0d cnt=%0d exp=1 cnt=1", seg_cnt - se0, bus.err_count);
    end
    checks++;
    if (fv_cnt - fv0 !== 0 || {bus.dig3, bus.dig2, bus.dig1, bus.dig0} !== 16'h1034) begin
      failures++;
      $display("FAIL seg_err_hold got=%0d %h exp=0 1034", fv_cnt - fv0,
               {bus.dig3, bus.dig2, bus.dig1, bus.dig0});
    end
    send_frame(S7, S0, S9, S5);
    checks++;
    if (fv_cnt - fv0 !== 1 || {bus.dig3, bus.dig2, bus.dig1, bus.dig0} !== 16'h7095) begin
      failures++;
      $display("FAIL seg_err_recover got=%0d %h exp=1 7095", fv_cnt - fv0,
               {bus.dig3, bus.dig2, bus.dig1, bus.dig0});
    end
  endtask

  task automatic test_seq_err;
    int fv0 = fv_cnt;
    int sq0 = seq_cnt;
    hold(4'b1000, S5, 40);
    hold(4'b0010, S3, 40);
    checks++;
    if (seq_cnt - sq0 !== 1 || bus.err_count !== 8'd2) begin
      failures++;
      $display("FAIL seq_err got=%0d cnt=%0d exp=1 cnt=2", seq_cnt - sq0, bus.err_count);
    end
    send_frame(S5, S6, S7, S8);
    checks++;
    if (fv_cnt - fv0 !== 1 || {bus.dig3, bus.dig2, bus.dig1, bus.dig0} !== 16'h5678) begin
      failures++;
      $display("FAIL seq_err_recover got=%0d %h exp=1 5678", fv_cnt - fv0,
               {bus.dig3, bus.dig2, bus.dig1, bus.dig0});
    end
  endtask

  task automatic test_glitch;
    int e0 = seg_cnt + scan_cnt + seq_cnt;
    int fv0 = fv_cnt;
    int sc0;
    bus.scan = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      bus.display = (i % 2 == 1) ? SX : S1;
      repeat (5) @(negedge clk);
    end
    checks++;
    if (seg_cnt + scan_cnt + seq_cnt - e0 !== 0 || fv_cnt - fv0 !== 0) begin
      failures++;
      $display("FAIL glitch_quiet got_err=%0d got_fv=%0d exp=0/0",
               seg_cnt + scan_cnt + seq_cnt - e0, fv_cnt - fv0);
    end
    sc0 = scan_cnt;
    hold(4'b1100, S1, 40);
    checks++;
    if (scan_cnt - sc0 !== 1 || bus.err_count !== 8'd3) begin
      failures++;
      $display("FAIL scan_err got=%0d cnt=%0d exp=1 cnt=3", scan_cnt - sc0, bus.err_count);
    end
  endtask

  task automatic test_timeout;
    send_frame(S1, S2, S3, S4);
    repeat (950) @(negedge clk);
    checks++;
    if (bus.link_lost !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early got=%b exp=0", bus.link_lost);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (bus.link_lost !== 1'b1) begin
      failures++;
      $display("FAIL timeout_late got=%b exp=1", bus.link_lost);
    end
    ll_at_fv = 1'b1;
    send_frame(S9, S8, S7, S6);
    checks++;
    if (bus.link_lost !== 1'b0 || ll_at_fv !== 1'b0
        || {bus.dig3, bus.dig2, bus.dig1, bus.dig0} !== 16'h9876) begin
      failures++;
      $display("FAIL timeout_recover got=%b at_fv=%b %h exp=0 0 9876", bus.link_lost,
               ll_at_fv, {bus.dig3, bus.dig2, bus.dig1, bus.dig0});
    end
  endtask

  task automatic test_reset_mid_frame;
    int fv0;
    hold(4'b1000, S9, 40);
    hold(4'b0100, S9, 40);
    hold(4'b0010, S9, 10);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.dig3, bus.dig2, bus.dig1, bus.dig0} !== 16'h0000 || bus.blank !== 4'b1111
        || bus.err_count !== 8'd0 || bus.link_lost !== 1'b1) begin
      failures++;
      $display("FAIL midreset got=%h/%b cnt=%0d ll=%b exp=0000/1111 cnt=0 ll=1",
               {bus.dig3, bus.dig2, bus.dig1, bus.dig0}, bus.blank, bus.err_count,
               bus.link_lost);
    end
    reset = 1'b0;
    fv0 = fv_cnt;
    hold(4'b0010, S9, 40);
    hold(4'b0001, S9, 40);
    checks++;
    if (fv_cnt - fv0 !== 0 || {bus.dig3, bus.dig2, bus.dig1, bus.dig0} !== 16'h0000
        || bus.blank !== 4'b1111) begin
      failures++;
      $display("FAIL midreset_partial got=%0d %h/%b exp=0 0000/1111", fv_cnt - fv0,
               {bus.dig3, bus.dig2, bus.dig1, bus.dig0}, bus.blank);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.scan    = 4'b1000;
    bus.display = S1;
    @(negedge clk);
    test_reset();
    test_frame();
    test_blank();
    test_seg_err();
    test_seq_err();
    test_glitch();
    test_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_receiver.md
SEG_SCAN_RECEIVER -- requirements
Module: seg_scan_receiver

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, consecutive identical synchronized samples required before a digit is captured (range 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 262144, clock cycles without a capture before link loss is declared.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scan  input  4  digit select from a multiplexed display driver, one-hot: 1000=digit3, 0100=digit2, 0010=digit1, 0001=digit0; asynchronous to clk.
REQ-006 display  input  7  segment lines, bit6..bit0 = a..g, active-high; asynchronous to clk.
REQ-007 dig3, dig2, dig1, dig0  output  4 each  last complete frame's decoded digit values.
REQ-008 blank  output  4  bit n=1 when digit n was blank (segments 0000000) in last frame.
REQ-009 frame_valid  output  1  one-cycle pulse when dig*/blank update.
REQ-010 seg_err, scan_err, seq_err  output  1 each  one-cycle error pulses.
REQ-011 err_count  output  8  saturating count of error pulses.
REQ-012 link_lost  output  1  level; no valid activity within TIMEOUT.

Function
REQ-013 SHALL pass scan and display through a 2-flop synchronizer before any use.
REQ-014 SHALL hold an 8-bit stability counter: cleared when the synchronized {scan,display} differs from the previous cycle's value, else incremented, saturating at STABLE_CYCLES.
REQ-015 SHALL generate a capture event in exactly the one cycle the counter reaches STABLE_CYCLES-1 (value unchanged for STABLE_CYCLES cycles); no further capture until the value changes.
REQ-016 On capture with scan not one-hot (0000, or two or more bits set) SHALL pulse scan_err and discard the sample; sequence FSM unchanged.
REQ-017 Segment decode: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 0000000=blank (value 0, blank flag 1).
REQ-018 Any other segment pattern SHALL pulse seg_err, discard the sample and return the FSM to WAIT3.
REQ-019 Sequence FSM states WAIT3, GOT3, GOT2, GOT1; reset state WAIT3.
REQ-020 Valid capture of digit3 in any state SHALL load shadow slot 3 and go to GOT3 (resynchronizes a frame).
REQ-021 GOT3+digit2 -> GOT2; GOT2+digit1 -> GOT1; GOT1+digit0 -> WAIT3 with frame completion; each loads its shadow slot.
REQ-022 Valid capture of any other digit out of order SHALL pulse seq_err and go to WAIT3; in WAIT3 captures of digit2/1/0 SHALL be ignored silently.
REQ-023 On frame completion, next cycle SHALL update dig3..dig0 and blank from shadow simultaneously and pulse frame_valid; outputs otherwise hold.
REQ-024 err_count SHALL increment by 1 per cycle in which any error pulse is asserted, saturating at 255.
REQ-025 Timeout counter SHALL clear on every valid capture, else increment; on reaching TIMEOUT SHALL set link_lost, return FSM to WAIT3, and hold at TIMEOUT.
REQ-026 link_lost SHALL clear in the cycle frame_valid pulses; if a capture and timeout coincide, the capture wins.
REQ-027 Total latency from pins stable to capture: 2 synchronizer cycles + STABLE_CYCLES.

Reset
REQ-028 reset SHALL set dig3..dig0=0, blank=1111, frame_valid=0, all error pulses=0, err_count=0, link_lost=1, FSM=WAIT3, all counters and synchronizers=0.
REQ-029 reset asserted mid-frame SHALL discard shadow contents; no frame_valid for that partial frame.

Verification
REQ-030 Scan 1000/0100/0010/0001 with segments for 1,2,3,4, each held 40 cycles -> one frame_valid; dig3..0=1,2,3,4, blank=0000, link_lost=0.
REQ-031 Same sequence with digit2 segments 0000000 -> dig2=0, blank=0100, frame_valid once.
REQ-032 Digit1 segments 1000000 -> seg_err one pulse, err_count=1, no frame_valid until next full 3-2-1-0 sequence.
REQ-033 Scan 1000 then 0010 (skipping digit2) -> seq_err pulse; following correct frame 5,6,7,8 -> outputs 5,6,7,8.
REQ-034 Glitch: display toggles every 5 cycles with STABLE_CYCLES=16 -> no capture, no errors; scan=1100 held 40 cycles -> exactly one scan_err.
REQ-035 TIMEOUT=1000, inputs frozen after one frame -> link_lost=1 at cycle 1000 after last capture; reset asserted during frame -> outputs return to REQ-028 values next cycle.
